// File: rtl/serial_slave_port.sv
// rtl/serial_slave_port.sv - serial bus slave endpoint: deserialises address/data write frames into a local memory
module serial_slave_port #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  address,
   input  logic                  data,
   input  logic                  valid,
   output logic                  ready,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  wr_strobe,
   output logic [ADDR_WIDTH-1:0] last_addr,
   output logic [DATA_WIDTH-1:0] last_data,
   output logic                  frame_err
);
   localparam int MAX_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
   localparam int CNT_W  = $clog2(MAX_W + 1);
   localparam int WAIT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, WAIT} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_sr;
   logic [DATA_WIDTH-1:0] data_sr;
   logic [CNT_W-1:0]      bit_cnt;
   logic [WAIT_W-1:0]     wait_cnt;
   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] wr_word;
   logic                  wr_en;

   // The memory is written on the edge that completes the frame, so WRITE is the first busy cycle.
   assign wr_word = (data_sr << 1) | DATA_WIDTH'(data);
   assign wr_en   = (state == DATA) && valid && (bit_cnt == CNT_W'(DATA_WIDTH - 1));
   assign ready   = (state == IDLE) || (state == ADDR) || (state == DATA);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         addr_sr   <= '0;
         data_sr   <= '0;
         bit_cnt   <= '0;
         wait_cnt  <= '0;
         wr_strobe <= 1'b0;
         frame_err <= 1'b0;
         last_addr <= '0;
         last_data <= '0;
      end else begin
         wr_strobe <= 1'b0;
         frame_err <= 1'b0;
         if ((state == ADDR || state == DATA) && !valid) begin
            state     <= IDLE;
            frame_err <= 1'b1;
            addr_sr   <= '0;
            data_sr   <= '0;
            bit_cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (valid) begin
                     addr_sr <= ADDR_WIDTH'(address);
                     if (ADDR_WIDTH == 1) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                     end else begin
                        state   <= ADDR;
                        bit_cnt <= CNT_W'(1);
                     end
                  end
               end
               ADDR: begin
                  addr_sr <= (addr_sr << 1) | ADDR_WIDTH'(address);
                  if (bit_cnt == CNT_W'(ADDR_WIDTH - 1)) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               DATA: begin
                  data_sr <= wr_word;
                  if (wr_en) begin
                     state     <= WRITE;
                     wr_strobe <= 1'b1;
                     last_addr <= addr_sr;
                     last_data <= wr_word;
                     bit_cnt   <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
               WRITE: begin
                  addr_sr <= '0;
                  data_sr <= '0;
                  if (WAIT_CYCLES > 0) begin
                     state    <= WAIT;
                     wait_cnt <= WAIT_W'(WAIT_CYCLES);
                  end else begin
                     state <= IDLE;
                  end
               end
               WAIT: begin
                  if (wait_cnt <= WAIT_W'(1)) begin
                     state    <= IDLE;
                     wait_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt - WAIT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr_sr] <= wr_word;
   end

   // Read-first: a same-edge write is only visible on the following read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rd_data <= '0;
      else        rd_data <= mem[rd_addr];
   end
endmodule
